// File: rtl/tia_biphase_monitor_if.sv
// Biphase clock bus lines as seen by the monitor, plus the monitor's status outputs.
// The master side is the generator/bench; the slave side is the monitor.
interface tia_biphase_monitor_if #(
   parameter int ERR_W = 8
);
   logic             phi1;
   logic             phi2;
   logic             bqb;
   logic             clr;
   logic             locked;
   logic [1:0]       phase;
   logic             period_strobe;
   logic             err_seq;
   logic             err_overlap;
   logic [ERR_W-1:0] err_count;

   modport master (
      output phi1, phi2, bqb, clr,
      input  locked, phase, period_strobe, err_seq, err_overlap, err_count
   );

   modport slave (
      input  phi1, phi2, bqb, clr,
      output locked, phase, period_strobe, err_seq, err_overlap, err_count
   );
endinterface

// File: rtl/tia_biphase_monitor.sv
// Passive checker of the TIA biphase P1/G1/P2/G2 sequence with lock, phase and fault reporting.
// One clk latency from sampled lines to registered outputs; drives nothing back, so no backpressure.
module tia_biphase_monitor #(
   parameter int LOCK_COUNT = 4,
   parameter int ERR_W      = 8
) (
   input logic                  clk,
   input logic                  r_n,
   tia_biphase_monitor_if.slave mon
);
   typedef enum logic [2:0] {HUNT, SEEN_P1, SEEN_G1, SEEN_P2, SEEN_G2} state_t;

   // Triples are {phi1, phi2, bqb}
   localparam logic [2:0]       TRIP_P1  = 3'b101;
   localparam logic [2:0]       TRIP_G1  = 3'b001;
   localparam logic [2:0]       TRIP_P2  = 3'b010;
   localparam logic [2:0]       TRIP_G2  = 3'b000;
   localparam logic [3:0]       GOOD_MAX = LOCK_COUNT;
   localparam logic [3:0]       GOOD_ONE = 1;
   localparam logic [ERR_W-1:0] CNT_MAX  = '1;
   localparam logic [ERR_W-1:0] CNT_ONE  = 1;

   state_t     state;
   state_t     state_match;
   logic [3:0] good_cnt;
   logic [2:0] samp;
   logic [2:0] trip_exp;
   logic [1:0] phase_match;
   logic       match;
   logic       overlap;
   logic       err_event;

   assign samp    = {mon.phi1, mon.phi2, mon.bqb};
   assign overlap = mon.phi1 & mon.phi2;

   // HUNT waits for P1 exactly like SEEN_G2 does; only the mismatch handling differs.
   always_comb begin
      trip_exp    = TRIP_P1;
      state_match = SEEN_P1;
      phase_match = 2'd0;
      case (state)
         SEEN_P1: begin
            trip_exp    = TRIP_G1;
            state_match = SEEN_G1;
            phase_match = 2'd1;
         end
         SEEN_G1: begin
            trip_exp    = TRIP_P2;
            state_match = SEEN_P2;
            phase_match = 2'd2;
         end
         SEEN_P2: begin
            trip_exp    = TRIP_G2;
            state_match = SEEN_G2;
            phase_match = 2'd3;
         end
         default: begin
            trip_exp    = TRIP_P1;
            state_match = SEEN_P1;
            phase_match = 2'd0;
         end
      endcase
   end

   assign match     = (samp == trip_exp);
   // An overlap can never match a tracked slot, so overlap+mismatch is still one event.
   assign err_event = overlap | ((state != HUNT) & ~match);

   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         state             <= HUNT;
         good_cnt          <= '0;
         mon.locked        <= 1'b0;
         mon.phase         <= 2'd0;
         mon.period_strobe <= 1'b0;
         mon.err_seq       <= 1'b0;
         mon.err_overlap   <= 1'b0;
         mon.err_count     <= '0;
      end else begin
         mon.period_strobe <= 1'b0;
         mon.err_seq       <= 1'b0;
         mon.err_overlap   <= overlap;

         if (match) begin
            state     <= state_match;
            mon.phase <= phase_match;
            if (state == SEEN_G2) begin
               mon.period_strobe <= 1'b1;
               if (good_cnt != GOOD_MAX) begin
                  good_cnt <= good_cnt + GOOD_ONE;
               end
               if (good_cnt >= GOOD_MAX - GOOD_ONE) begin
                  mon.locked <= 1'b1;
               end
            end
         end else if (state != HUNT) begin
            mon.err_seq <= 1'b1;
            state       <= HUNT;
            good_cnt    <= '0;
            mon.locked  <= 1'b0;
            mon.phase   <= 2'd0;
         end

         if (mon.clr) begin
            mon.err_count <= '0;
         end else if (err_event && (mon.err_count != CNT_MAX)) begin
            mon.err_count <= mon.err_count + CNT_ONE;
         end
      end
   end
endmodule

// File: tb/tb_tia_biphase_monitor.sv
// Randomized and directed bench for tia_biphase_monitor against a slot-index reference model.
module tb_tia_biphase_monitor;
   localparam int LOCK = 4;
   localparam int EW   = 8;
   localparam int CMAX = (1 << EW) - 1;

   logic clk = 1'b0;
   logic r_n = 1'b0;

   tia_biphase_monitor_if #(.ERR_W(EW)) bus ();

   tia_biphase_monitor #(.LOCK_COUNT(LOCK), .ERR_W(EW)) dut (
      .clk (clk),
      .r_n (r_n),
      .mon (bus.slave)
   );

   always #5 clk = ~clk;

   logic [2:0] seq_tab [4];
   int checks   = 0;
   int failures = 0;

   // Reference model: slot index in the 4-slot cycle, -1 while hunting
   int m_slot = -1;
   int m_good = 0;
   int m_cnt  = 0;
   bit e_lock = 1'b0;
   bit e_strb = 1'b0;
   bit e_seq  = 1'b0;
   bit e_ovl  = 1'b0;
   int e_phase = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_slot  = -1;
      m_good  = 0;
      m_cnt   = 0;
      e_lock  = 1'b0;
      e_strb  = 1'b0;
      e_seq   = 1'b0;
      e_ovl   = 1'b0;
      e_phase = 0;
   endtask

   task automatic model_step(input logic [2:0] s, input logic c);
      int idx;
      idx = -1;
      if (!r_n) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 4; i++) if (seq_tab[i] == s) idx = i;
      e_strb = 1'b0;
      e_seq  = 1'b0;
      e_ovl  = s[2] & s[1];
      if (m_slot < 0) begin
         if (idx == 0) m_slot = 0;
      end else if (idx == (m_slot + 1) % 4) begin
         if (idx == 0) begin
            e_strb = 1'b1;
            if (m_good < LOCK) m_good++;
         end
         m_slot = idx;
      end else begin
         e_seq  = 1'b1;
         m_slot = -1;
         m_good = 0;
      end
      e_phase = (m_slot < 0) ? 0 : m_slot;
      e_lock  = (m_good == LOCK);
      if (c) m_cnt = 0;
      else if ((e_seq || e_ovl) && m_cnt < CMAX) m_cnt++;
   endtask

   // Drive one sample at negedge; return just after the edge that registers it.
   task automatic cyc(input logic [2:0] s, input logic c = 1'b0);
      @(negedge clk);
      bus.phi1 = s[2];
      bus.phi2 = s[1];
      bus.bqb  = s[0];
      bus.clr  = c;
      model_step(s, c);
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      r_n = 1'b0;
      model_reset();
      cyc(3'b000);
      cyc(3'b000);
      r_n = 1'b1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         chk("locked", bus.locked, e_lock);
         chk("phase", bus.phase, e_phase);
         chk("period_strobe", bus.period_strobe, e_strb);
         chk("err_seq", bus.err_seq, e_seq);
         chk("err_overlap", bus.err_overlap, e_ovl);
         chk("err_count", bus.err_count, m_cnt);
      end
   end

   initial begin
      int g;
      int r;
      int n;
      logic c;
      seq_tab[0] = 3'b101;
      seq_tab[1] = 3'b001;
      seq_tab[2] = 3'b010;
      seq_tab[3] = 3'b000;
      bus.phi1 = 1'b0;
      bus.phi2 = 1'b0;
      bus.bqb  = 1'b0;
      bus.clr  = 1'b0;

      do_reset();
      chk("rst_locked", bus.locked, 0);
      chk("rst_phase", bus.phase, 0);
      chk("rst_errcnt", bus.err_count, 0);

      // Clean stream: strobes every 4 cycles after first P1, lock with the 4th
      for (int k = 0; k < 24; k++) begin
         cyc(seq_tab[k % 4]);
         chk("t1_strobe", bus.period_strobe, (k > 0 && k % 4 == 0));
         chk("t1_locked", bus.locked, (k >= 16));
         chk("t1_phase", bus.phase, k % 4);
      end
      chk("t1_errcnt", bus.err_count, 0);

      // Bad triple in a P2 slot while locked
      cyc(3'b101);
      cyc(3'b001);
      cyc(3'b001);
      chk("t2_err_seq", bus.err_seq, 1);
      chk("t2_locked", bus.locked, 0);
      chk("t2_phase", bus.phase, 0);
      chk("t2_errcnt", bus.err_count, 1);
      cyc(3'b000);
      chk("t2_quiet", bus.err_seq, 0);
      for (int k = 0; k < 17; k++) begin
         cyc(seq_tab[k % 4]);
         chk("t2_relock", bus.locked, (k >= 16));
      end
      chk("t2_errcnt_end", bus.err_count, 1);

      // Overlap in HUNT, then overlap as a G1 mismatch
      do_reset();
      cyc(3'b111);
      chk("t3_ovl", bus.err_overlap, 1);
      chk("t3_seq", bus.err_seq, 0);
      chk("t3_cnt", bus.err_count, 1);
      cyc(3'b101);
      cyc(3'b110);
      chk("t3_ovl2", bus.err_overlap, 1);
      chk("t3_seq2", bus.err_seq, 1);
      chk("t3_cnt2", bus.err_count, 2);

      // Generator reset for 3 cycles while in SEEN_P1
      do_reset();
      cyc(3'b101);
      cyc(3'b000);
      chk("t4_seq", bus.err_seq, 1);
      chk("t4_cnt", bus.err_count, 1);
      for (int k = 0; k < 2; k++) begin
         cyc(3'b000);
         chk("t4_quiet_seq", bus.err_seq, 0);
         chk("t4_quiet_cnt", bus.err_count, 1);
      end
      for (int k = 0; k < 17; k++) begin
         cyc(seq_tab[k % 4]);
         chk("t4_relock", bus.locked, (k >= 16));
      end

      // Saturation and clr priority
      do_reset();
      repeat (300) cyc(3'b111);
      chk("t5_sat", bus.err_count, 255);
      cyc(3'b111, 1'b1);
      chk("t5_clr", bus.err_count, 0);
      chk("t5_clr_ovl", bus.err_overlap, 1);

      // Async reset between edges while locked
      do_reset();
      cyc(3'b111);
      for (int k = 0; k < 19; k++) cyc(seq_tab[k % 4]);
      chk("t6_pre_locked", bus.locked, 1);
      chk("t6_pre_phase", bus.phase, 2);
      chk("t6_pre_cnt", bus.err_count, 1);
      #1;
      r_n = 1'b0;
      model_reset();
      #1;
      chk("t6_async_locked", bus.locked, 0);
      chk("t6_async_phase", bus.phase, 0);
      chk("t6_async_cnt", bus.err_count, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(seq_tab[(k + 3) % 4]);
         chk("t6_hold_locked", bus.locked, 0);
         chk("t6_hold_cnt", bus.err_count, 0);
      end
      r_n = 1'b1;

      // Randomized: mostly clean stream with glitches, generator resets and clr
      g = 0;
      for (int k = 0; k < 3000; k++) begin
         r = $urandom_range(0, 99);
         c = ($urandom_range(0, 31) == 0);
         if (r < 5) begin
            cyc(3'($urandom_range(0, 7)), c);
         end else if (r < 7) begin
            n = $urandom_range(1, 4);
            repeat (n) cyc(3'b000, c);
            g = 0;
         end else begin
            cyc(seq_tab[g], c);
            g = (g + 1) % 4;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/tia_biphase_monitor.md
Name: tia_biphase_monitor

Overview:
- Receive-side checker for the TIA biphase clock bus (phi1, phi2, bqb).
- Samples the three lines on the master clock and tracks the expected 4-cycle sequence P1, G1, P2, G2.
- Reports lock, recovered phase, per-period strobe, sequence/overlap fault pulses and a saturating fault count.
- Sits beside the biphase clock generator in TIA simulation benches and self-check logic. It is a passive observer and drives nothing back.

Parameters:
- LOCK_COUNT, 4, number of consecutive clean periods required before locked asserts (legal 1..15).
- ERR_W, 8, width of err_count.

Ports:
- clk  input  1  master clock; same clock that drives the generator.
- r_n  input  1  asynchronous active-low reset.
- phi1  input  1  biphase phase-1 line.
- phi2  input  1  biphase phase-2 line.
- bqb  input  1  generator bqb line (high during P1 and G1).
- clr  input  1  synchronous clear of err_count only.
- locked  output  1  sequence verified for LOCK_COUNT consecutive periods.
- phase  output  2  last matched slot: 0=P1, 1=G1, 2=P2, 3=G2; holds 0 while hunting.
- period_strobe  output  1  one-cycle pulse on each clean G2->P1 completion.
- err_seq  output  1  one-cycle pulse on a sequence mismatch.
- err_overlap  output  1  one-cycle pulse when phi1 and phi2 are both sampled high.
- err_count  output  ERR_W  saturating count of error events.

Behaviour:
- Reset (r_n low, async): state HUNT; good-period counter 0; err_count 0. All outputs low or zero, phase=0. Outputs stay cleared while r_n is low.
- Sampling: inputs are sampled on posedge clk as a triple S=(phi1,phi2,bqb). All outputs are registered and reflect the sample taken at that edge, so there is one clk of latency.
- Expected triples: P1=(1,0,1), G1=(0,0,1), P2=(0,1,0), G2=(0,0,0).
- States: HUNT, SEEN_P1, SEEN_G1, SEEN_P2, SEEN_G2.
- HUNT:
  - S=P1: go to SEEN_P1, phase=0.
  - phi1&phi2: err_overlap pulse, stay in HUNT.
  - Any other S: stay in HUNT, no error. An idle or reset generator is legal here.
- Tracking states: the expected next triple is G1 from SEEN_P1, P2 from SEEN_G1, G2 from SEEN_P2, and P1 from SEEN_G2.
  - Match: advance to the matching state and update phase.
  - SEEN_G2 -> SEEN_P1 match: assert period_strobe and increment the good counter, saturating at LOCK_COUNT.
  - Mismatch: err_seq pulse; go to HUNT (not to SEEN_P1, even if S==P1); good counter=0; locked=0; phase=0.
  - If the mismatching S has phi1&phi2: err_overlap pulses as well as err_seq. This counts as one error event.
- locked: asserts on the edge where the good counter reaches LOCK_COUNT. It stays high until a mismatch or reset. The first P1 taken from HUNT does not count as a completed period.
- err_count:
  - +1 per error event (err_seq or err_overlap in that cycle); saturates at 2^ERR_W-1.
  - clr has priority over an increment in the same cycle; the result is 0.
- Generator reset mid-run: it drives (0,0,0). From SEEN_P1 or SEEN_G1 this is a mismatch, giving an error and HUNT. From SEEN_P2 it matches G2, and the next edge (0,0,0) then mismatches P1.
- No combinational path from the inputs to the outputs.

Test Plan:
- Reset, then a clean generator stream starting at P1 for 6 periods -> period_strobe at cycles 4, 8, 12, 16, 20 after first P1. locked rises with the 4th strobe (cycle 16). err_count=0. phase cycles 0,1,2,3.
- Locked stream, force (0,0,1) in a P2 slot -> err_seq pulse one clk later. locked=0, phase=0, err_count=1. Relock after 4 further clean periods.
- In HUNT drive (1,1,1) -> err_overlap=1, err_seq=0, err_count=1. While tracking drive (1,1,0) at G1 -> both flags pulse, err_count=2.
- Generator reset asserted for 3 cycles while state SEEN_P1 -> single err_seq, then quiet HUNT with no further errors. Release -> clean reacquisition and locked after 4 periods.
- Inject 300 overlap samples with ERR_W=8 -> err_count saturates at 255. Assert clr in the same cycle as another error -> err_count=0.
- Assert r_n low asynchronously between clk edges while locked -> locked, phase and err_count go to 0 immediately. They remain 0 until r_n deasserts.
